// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache, 2-word blocks, same-cycle hits, 2-beat refill, flush and hit counter
module icache_dm #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic [WORD_W-1:0] iload,
  input  logic              iwait,
  output logic [31:0]       hit_count
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = WORD_W - 3 - IDXW;
  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;
  state_t state, state_n;
  logic [SETS-1:0] valid;
  logic [TAGW-1:0] tags [SETS];
  logic [WORD_W-1:0] d0 [SETS];
  logic [WORD_W-1:0] d1 [SETS];
  logic [TAGW-1:0] a_tag, m_tag;
  logic [IDXW-1:0] a_idx, m_idx;
  logic [WORD_W-1:0] buf0;
  logic unused_byte_off;
  assign unused_byte_off = ^imemaddr[1:0];
  assign a_tag = imemaddr[WORD_W-1:3+IDXW];
  assign a_idx = imemaddr[2+IDXW:3];
  always_comb begin
    ihit     = state == IDLE && imemREN && !flush && valid[a_idx] && tags[a_idx] == a_tag;
    imemload = ihit ? (imemaddr[2] ? d1[a_idx] : d0[a_idx]) : '0;
    iREN     = state != IDLE;
    iaddr    = state == FETCH0 ? {m_tag, m_idx, 3'b000} : state == FETCH1 ? {m_tag, m_idx, 3'b100} : '0;
    state_n  = flush ? IDLE :
               state == IDLE   ? (imemREN && !ihit ? FETCH0 : IDLE) :
               state == FETCH0 ? (iwait ? FETCH0 : FETCH1) :
                                 (iwait ? FETCH1 : IDLE);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      hit_count <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        valid     <= '0;
        hit_count <= '0;
      end else begin
        if (ihit) hit_count <= hit_count + 32'd1;
        if (state == IDLE && imemREN && !ihit) begin
          m_tag <= a_tag;
          m_idx <= a_idx;
        end
        if (state == FETCH0 && !iwait) buf0 <= iload;
        if (state == FETCH1 && !iwait) begin
          valid[m_idx] <= 1'b1;
          tags[m_idx]  <= m_tag;
          d0[m_idx]    <= buf0;
          d1[m_idx]    <= iload;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: table-driven directed bench for icache_dm plus a hit_count wrap sequence
module tb_icache_dm;
  logic        clk = 1'b0;
  logic        rst, imem_ren, ihit, flush, iren, iwait;
  logic [31:0] imem_addr, imem_load, iaddr, iload, hit_count;
  int pass_cnt = 0;
  int total    = 0;
  typedef struct {
    bit          chk, r, f, n;
    logic [31:0] a, l;
    bit          w, h;
    logic [31:0] el;
    bit          ei;
    logic [31:0] ea, hc;
  } vec_t;
  vec_t q[$];
  icache_dm dut (
    .CLK(clk), .RST(rst), .imemREN(imem_ren), .imemaddr(imem_addr), .ihit(ihit),
    .imemload(imem_load), .flush(flush), .iREN(iren), .iaddr(iaddr), .iload(iload),
    .iwait(iwait), .hit_count(hit_count)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(bit c, bit r, bit f, bit n, logic [31:0] a, logic [31:0] l, bit w,
                              bit h, logic [31:0] el, bit ei, logic [31:0] ea, logic [31:0] hc);
    vec_t v;
    v.chk = c; v.r = r; v.f = f; v.n = n; v.a = a; v.l = l; v.w = w;
    v.h = h; v.el = el; v.ei = ei; v.ea = ea; v.hc = hc;
    return v;
  endfunction
  task automatic cmp(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
  endtask
  task automatic step(vec_t v, int idx);
    rst = v.r; flush = v.f; imem_ren = v.n; imem_addr = v.a; iload = v.l; iwait = v.w;
    #4;
    if (v.chk) begin
      cmp("ihit", idx, {31'd0, ihit}, {31'd0, v.h});
      cmp("imemload", idx, imem_load, v.el);
      cmp("iREN", idx, {31'd0, iren}, {31'd0, v.ei});
      cmp("iaddr", idx, iaddr, v.ea);
      cmp("hit_count", idx, hit_count, v.hc);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; imem_ren = 1'b0; imem_addr = '0; iload = '0; iwait = 1'b0;
    //            c  r  f  n  addr    iload         w  h  imemload      iR iaddr   hc
    q.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h11111111, 0, 0, 32'h0,        1, 32'h40,  0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h22222222, 0, 0, 32'h0,        1, 32'h44,  0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h0,        0, 1, 32'h11111111, 0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h44,  32'h0,        0, 1, 32'h22222222, 0, 32'h0,   1));
    q.push_back(mk(1, 0, 0, 0, 32'h44,  32'h0,        0, 0, 32'h0,        0, 32'h0,   2));
    q.push_back(mk(1, 0, 0, 1, 32'h440, 32'h0,        0, 0, 32'h0,        0, 32'h0,   2));
    q.push_back(mk(1, 0, 0, 1, 32'h440, 32'h33333333, 0, 0, 32'h0,        1, 32'h440, 2));
    q.push_back(mk(1, 0, 0, 1, 32'h440, 32'h44444444, 0, 0, 32'h0,        1, 32'h444, 2));
    q.push_back(mk(1, 0, 0, 1, 32'h444, 32'h0,        0, 1, 32'h44444444, 0, 32'h0,   2));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h0,        0, 0, 32'h0,        0, 32'h0,   3));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h11111111, 0, 0, 32'h0,        1, 32'h40,  3));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h22222222, 0, 0, 32'h0,        1, 32'h44,  3));
    q.push_back(mk(1, 0, 0, 1, 32'h44,  32'h0,        0, 1, 32'h22222222, 0, 32'h0,   3));
    q.push_back(mk(1, 0, 0, 1, 32'h80,  32'h0,        0, 0, 32'h0,        0, 32'h0,   4));
    q.push_back(mk(1, 0, 0, 0, 32'h0,   32'h55555555, 0, 0, 32'h0,        1, 32'h80,  4));
    q.push_back(mk(1, 0, 0, 0, 32'h0,   32'h66666666, 0, 0, 32'h0,        1, 32'h84,  4));
    q.push_back(mk(1, 0, 0, 1, 32'h84,  32'h0,        0, 1, 32'h66666666, 0, 32'h0,   4));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h0,        0, 0, 32'h0,        0, 32'h0,   5));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h0,        1, 0, 32'h0,        1, 32'h100, 5));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h0,        1, 0, 32'h0,        1, 32'h100, 5));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h77777777, 0, 0, 32'h0,        1, 32'h100, 5));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h0,        1, 0, 32'h0,        1, 32'h104, 5));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h0,        1, 0, 32'h0,        1, 32'h104, 5));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h88888888, 0, 0, 32'h0,        1, 32'h104, 5));
    q.push_back(mk(1, 0, 0, 1, 32'h100, 32'h0,        0, 1, 32'h77777777, 0, 32'h0,   5));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h0,        0, 1, 32'h11111111, 0, 32'h0,   6));
    q.push_back(mk(1, 0, 0, 1, 32'h200, 32'h0,        0, 0, 32'h0,        0, 32'h0,   7));
    q.push_back(mk(1, 0, 0, 1, 32'h200, 32'h99999999, 0, 0, 32'h0,        1, 32'h200, 7));
    q.push_back(mk(1, 0, 0, 1, 32'h200, 32'h0,        1, 0, 32'h0,        1, 32'h204, 7));
    q.push_back(mk(1, 0, 1, 1, 32'h200, 32'h0,        1, 0, 32'h0,        1, 32'h204, 7));
    q.push_back(mk(1, 0, 0, 0, 32'h200, 32'h0,        1, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h11111111, 0, 0, 32'h0,        1, 32'h40,  0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h22222222, 0, 0, 32'h0,        1, 32'h44,  0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h0,        0, 1, 32'h11111111, 0, 32'h0,   0));
    q.push_back(mk(1, 0, 1, 1, 32'h40,  32'h0,        0, 0, 32'h0,        0, 32'h0,   1));
    q.push_back(mk(1, 0, 0, 1, 32'h44,  32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h44,  32'h11111111, 0, 0, 32'h0,        1, 32'h40,  0));
    q.push_back(mk(1, 0, 0, 1, 32'h44,  32'h22222222, 0, 0, 32'h0,        1, 32'h44,  0));
    q.push_back(mk(1, 0, 0, 1, 32'h44,  32'h0,        0, 1, 32'h22222222, 0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h300, 32'h0,        0, 0, 32'h0,        0, 32'h0,   1));
    q.push_back(mk(1, 1, 0, 1, 32'h300, 32'h0,        1, 0, 32'h0,        1, 32'h300, 1));
    q.push_back(mk(1, 0, 0, 1, 32'h44,  32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 0, 32'h44,  32'h0,        1, 0, 32'h0,        1, 32'h40,  0));
    q.push_back(mk(1, 0, 0, 0, 32'h44,  32'h0,        1, 0, 32'h0,        1, 32'h40,  0));
    q.push_back(mk(0, 1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'h0,        0, 0, 32'h0,        0, 32'h0,   0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'hAAAAAAAA, 0, 0, 32'h0,        1, 32'h40,  0));
    q.push_back(mk(1, 0, 0, 1, 32'h40,  32'hBBBBBBBB, 0, 0, 32'h0,        1, 32'h44,  0));
    #1;
    for (int i = 0; i < q.size(); i++) step(q[i], i);
    rst = 1'b0; flush = 1'b0; imem_ren = 1'b1; imem_addr = 32'h40; iwait = 1'b0;
    #4;
    cmp("wrap_ihit", 0, {31'd0, ihit}, 32'd1);
    cmp("wrap_load", 0, imem_load, 32'hAAAAAAAA);
    force dut.hit_count = 32'hFFFFFFFF;
    #1;
    release dut.hit_count;
    @(posedge clk);
    #1;
    cmp("wrap_count", 0, hit_count, 32'd0);
    imem_addr = 32'h44;
    #4;
    cmp("wrap_load2", 1, imem_load, 32'hBBBBBBBB);
    @(posedge clk);
    #1;
    cmp("wrap_count2", 1, hit_count, 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
